// File: rtl/client_burst_arb_pkg.sv
// Shared types for the memory-port arbiter and related schedulers.
package client_burst_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_states_t;

  typedef enum logic [1:0] {
    SORT_IDLE = 2'd0,
    SORT_LOAD = 2'd1,
    SORT_RUN  = 2'd2,
    SORT_DONE = 2'd3
  } sorter_states_t;

  localparam int ABANDON_CYCLES_C = 2;

endpackage

// File: rtl/client_burst_arb_if.sv
// Client/memory handshake bundle between the clients and the arbiter.
interface client_burst_arb_if #(
  parameter int N = 3,
  parameter int W = $clog2(N)
);
  logic [N*W-1:0] prio_list;
  logic [N-1:0]   cli_req;
  logic [N-1:0]   cli_last;
  logic [N-1:0]   cli_gnt;
  logic           mem_valid;
  logic           mem_ready;
  logic [W-1:0]   mem_sel;
  logic           busy;

  modport slave (
    input  prio_list, cli_req, cli_last, mem_ready,
    output cli_gnt, mem_valid, mem_sel, busy
  );

  modport master (
    output prio_list, cli_req, cli_last, mem_ready,
    input  cli_gnt, mem_valid, mem_sel, busy
  );
endinterface

// File: rtl/client_burst_arb_prio_pick.sv
// Rank scan: first rank whose client is requesting wins.
module prio_pick #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N*W-1:0] i_prio_list,
  input  logic [N-1:0]   i_req,
  output logic [W-1:0]   o_idx,
  output logic           o_found
);
  logic [W-1:0] w_rank;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_rank  = '0;
    for (int k = 0; k < N; k++) begin
      w_rank = i_prio_list[k*W +: W];
      if (!o_found && int'(w_rank) < N) begin
        if (i_req[w_rank]) begin
          o_found = 1'b1;
          o_idx   = w_rank;
        end
      end
    end
  end
endmodule

// File: rtl/client_burst_arb.sv
// Burst-locking memory port arbiter driven by a priority list.
// Optional starvation guard: define MARB_STARVE_GUARD_EN.
module client_burst_arb
  import client_burst_arb_pkg::*;
#(
  parameter int MEM_ARB_CLIENTS_P = 3,
  parameter int MAX_BURST_P       = 4,
  parameter int CLIENTS_BWIDTH_P  = $clog2(MEM_ARB_CLIENTS_P),
  parameter int STARVE_LIMIT_P    = 7
) (
  input logic               clk,
  input logic               rst,
  client_burst_arb_if.slave bus
);
  localparam int N  = MEM_ARB_CLIENTS_P;
  localparam int W  = CLIENTS_BWIDTH_P;
  localparam int CW = $clog2(MAX_BURST_P) + 1;
  localparam int DW = $clog2(ABANDON_CYCLES_C) + 1;

  arb_states_t   r_state;
  logic [W-1:0]  r_sel;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_drop;

  logic          w_found;
  logic [W-1:0]  w_pick;
  logic [W-1:0]  w_win;
  logic          w_any;
  logic [CW-1:0] w_lim;
  logic          w_req_own;
  logic          w_acc;
  logic          w_end;

  prio_pick #(.N(N), .W(W)) u_pick (
    .i_prio_list (bus.prio_list),
    .i_req       (bus.cli_req),
    .o_idx       (w_pick),
    .o_found     (w_found)
  );

`ifdef MARB_STARVE_GUARD_EN
  logic [2:0]   r_loss [N];
  logic         r_gburst;
  logic         w_gfound;
  logic [W-1:0] w_gidx;

  always_comb begin
    w_gfound = 1'b0;
    w_gidx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.cli_req[i] && int'(r_loss[i]) >= STARVE_LIMIT_P) begin
        w_gfound = 1'b1;
        w_gidx   = W'(i);
      end
    end
  end

  assign w_win = w_gfound ? w_gidx : w_pick;
  assign w_any = w_found | w_gfound;
  assign w_lim = r_gburst ? CW'(1) : CW'(MAX_BURST_P);

  // Loss counters move only on an arbitration decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gburst <= 1'b0;
      for (int i = 0; i < N; i++) r_loss[i] <= '0;
    end else if (r_state == ARB_IDLE && w_any) begin
      r_gburst <= w_gfound;
      for (int i = 0; i < N; i++) begin
        if (W'(i) == w_win) r_loss[i] <= '0;
        else if (bus.cli_req[i] && r_loss[i] != 3'd7)
          r_loss[i] <= r_loss[i] + 3'd1;
      end
    end
  end
`else
  assign w_win = w_pick;
  assign w_any = w_found;
  assign w_lim = CW'(MAX_BURST_P);
`endif

  assign w_req_own     = bus.cli_req[r_sel];
  assign bus.mem_valid = (r_state == ARB_OWN) && w_req_own;
  assign bus.mem_sel   = r_sel;
  assign bus.busy      = (r_state == ARB_OWN);
  assign w_acc         = bus.mem_valid && bus.mem_ready;
  assign w_end         = w_acc &&
    (bus.cli_last[r_sel] || r_cnt == w_lim - 1'b1);

  always_comb begin
    bus.cli_gnt = '0;
    if (w_acc) bus.cli_gnt[r_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_drop  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_OWN;
            r_sel   <= w_win;
            r_cnt   <= '0;
            r_drop  <= '0;
          end
        end
        ARB_OWN: begin
          if (w_acc) begin
            r_cnt  <= r_cnt + 1'b1;
            r_drop <= '0;
            if (w_end) r_state <= ARB_IDLE;
          end else if (!w_req_own) begin
            // Owner went quiet: give the port back after the timeout.
            if (r_drop == DW'(ABANDON_CYCLES_C - 1)) r_state <= ARB_IDLE;
            r_drop <= r_drop + 1'b1;
          end else begin
            r_drop <= '0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_client_burst_arb.sv
// Randomized and directed bench for client_burst_arb against a burst-level model.
module tb_client_burst_arb;
  localparam int N  = 3;
  localparam int W  = 2;
  localparam int MB = 4;
  localparam int PW = N * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  client_burst_arb_if #(.N(N), .W(W)) bus ();

  client_burst_arb #(
    .MEM_ARB_CLIENTS_P (N),
    .MAX_BURST_P       (MB),
    .STARVE_LIMIT_P    (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int m_own, m_beats, m_drops, m_sel;
  int m_loss [N];
  bit m_g1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pk(input int r0, input int r1,
                                       input int r2);
    logic [31:0] t;
    t = r0 | (r1 << W) | (r2 << (2 * W));
    return t[PW-1:0];
  endfunction

  function automatic int scan(input logic [PW-1:0] pl,
                              input logic [N-1:0] req);
    int r;
    for (int k = 0; k < N; k++) begin
      r = (int'(pl) >> (k * W)) & ((1 << W) - 1);
      if (r < N && req[r]) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_beats = 0; m_drops = 0; m_sel = 0; m_g1 = 0;
    for (int i = 0; i < N; i++) m_loss[i] = 0;
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] last,
                      input logic rdy, input logic [PW-1:0] pl);
    logic         e_valid;
    logic [N-1:0] e_gnt;
    int           w;
    int           lim;
    bit           g;
    @(posedge clk);
    #1;
    bus.cli_req = req; bus.cli_last = last;
    bus.mem_ready = rdy; bus.prio_list = pl;
    #3;
    e_valid = (m_own >= 0) && req[m_own];
    e_gnt   = '0;
    if (e_valid && rdy) e_gnt[m_own] = 1'b1;
    chk("mem_valid", bus.mem_valid, e_valid);
    chk("cli_gnt", bus.cli_gnt, e_gnt);
    chk("busy", bus.busy, m_own >= 0);
    chk("mem_sel", bus.mem_sel, m_sel);
    lim = m_g1 ? 1 : MB;
    if (m_own < 0) begin
      w = -1; g = 0;
`ifdef MARB_STARVE_GUARD_EN
      for (int i = 0; i < N; i++)
        if (w < 0 && req[i] && m_loss[i] >= 7) begin w = i; g = 1; end
`endif
      if (w < 0) w = scan(pl, req);
      if (w >= 0) begin
`ifdef MARB_STARVE_GUARD_EN
        for (int i = 0; i < N; i++)
          if (i == w) m_loss[i] = 0;
          else if (req[i] && m_loss[i] < 7) m_loss[i]++;
`endif
        m_g1 = g; m_own = w; m_sel = w; m_beats = 0; m_drops = 0;
      end
    end else if (req[m_own]) begin
      m_drops = 0;
      if (rdy) begin
        m_beats++;
        if (last[m_own] || m_beats == lim) m_own = -1;
      end
    end else begin
      m_drops++;
      if (m_drops == 2) m_own = -1;
    end
  endtask

  task automatic settle();
    repeat (4) step('0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [PW-1:0] pl;
    int cnt;
    bus.cli_req = '0; bus.cli_last = '0;
    bus.mem_ready = 1'b0; bus.prio_list = '0;
    model_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_valid", bus.mem_valid, 0);
    chk("rst_gnt", bus.cli_gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sel", bus.mem_sel, 0);
    @(negedge clk) rst = 1'b1;

    pl = pk(0, 1, 2);
    step(3'b110, 3'b000, 1, pl);
    step(3'b110, 3'b000, 1, pl);
    chk("t1_gnt1", bus.cli_gnt, 3'b010);
    step(3'b110, 3'b010, 1, pl);
    chk("t1_gnt2", bus.cli_gnt, 3'b010);
    step(3'b100, 3'b000, 1, pl);
    chk("t1_idle", bus.busy, 0);
    step(3'b100, 3'b100, 1, pl);
    chk("t1_sel2", bus.mem_sel, 2);

    pl = pk(2, 0, 1);
    cnt = 0;
    step(3'b111, 3'b000, 1, pl);
    repeat (4) begin
      step(3'b111, 3'b000, 1, pl);
      cnt += int'(bus.cli_gnt[2]);
    end
    chk("t2_beats", cnt, 4);
    step(3'b111, 3'b000, 1, pl);
    chk("t2_idle", bus.busy, 0);
    step(3'b111, 3'b000, 1, pl);
    chk("t2_regnt", bus.cli_gnt, 3'b100);
    settle();

    pl = pk(0, 1, 2);
    step(3'b001, 3'b000, 0, pl);
    repeat (5) begin
      step(3'b001, 3'b000, 0, pl);
      chk("t3_hold", {bus.mem_valid, bus.cli_gnt}, 4'b1000);
    end
    step(3'b001, 3'b001, 1, pl);
    chk("t3_beat", bus.cli_gnt, 3'b001);
    settle();

    step(3'b011, 3'b000, 1, pk(0, 1, 2));
    step(3'b011, 3'b000, 1, pk(1, 0, 2));
    chk("t4_keep0", bus.cli_gnt, 3'b001);
    step(3'b011, 3'b001, 1, pk(1, 0, 2));
    step(3'b011, 3'b000, 1, pk(1, 0, 2));
    step(3'b011, 3'b010, 1, pk(1, 0, 2));
    chk("t4_sel1", bus.mem_sel, 1);
    settle();

    step(3'b001, 3'b000, 1, pl);
    step(3'b000, 3'b000, 1, pl);
    step(3'b000, 3'b000, 1, pl);
    chk("t5_nognt", bus.cli_gnt, 0);
    step(3'b000, 3'b000, 1, pl);
    chk("t5_idle", bus.busy, 0);

    step(3'b111, 3'b000, 0, pk(2, 0, 1));
    step(3'b111, 3'b000, 0, pk(2, 0, 1));
    chk("t6_pre", bus.mem_sel, 2);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_valid", bus.mem_valid, 0);
    chk("t6_gnt", bus.cli_gnt, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_sel", bus.mem_sel, 0);
    bus.cli_req = '0; bus.cli_last = '0; bus.mem_ready = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;

`ifdef MARB_STARVE_GUARD_EN
    pl = pk(0, 1, 2);
    repeat (7) begin
      step(3'b101, 3'b000, 1, pl);
      step(3'b101, 3'b001, 1, pl);
    end
    step(3'b101, 3'b000, 1, pl);
    step(3'b101, 3'b000, 1, pl);
    chk("g_gnt2", bus.cli_gnt, 3'b100);
    step(3'b101, 3'b000, 1, pl);
    chk("g_one", bus.busy, 0);
    settle();
`endif

    repeat (600) begin
      logic [N-1:0] rq, ls;
      for (int i = 0; i < N; i++) begin
        rq[i] = ($urandom_range(0, 9) < 7);
        ls[i] = ($urandom_range(0, 9) < 3);
      end
      step(rq, ls, $urandom_range(0, 9) < 7, PW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
